// File: rtl/adbg_wb_pkg.sv
// Shared types and defaults for the debug-bridge WishBone transaction engine.
package adbg_wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_BUS   = 2'd2,
        S_DONE  = 2'd3
    } xfer_state_e;

    localparam int ADBG_ADDR_W      = 32;
    localparam int ADBG_DATA_W      = 32;
    localparam int ADBG_TIMEOUT_DEF = 255;

endpackage

// File: rtl/adbg_wb_timeout.sv
// Loadable up-counter with clear/enable; tc_o flags the last allowed cycle.
module adbg_wb_timeout
    import adbg_wb_pkg::*;
#(
    parameter int MAX = ADBG_TIMEOUT_DEF,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (load_i) cnt_d = load_val_i;
        else if (en_i)   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Terminal one cycle early so the access lasts exactly MAX bus cycles.
    assign tc_o = (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/adbg_wb_xfer_engine.sv
// WB-domain engine: accepts a synchronised request, runs one WishBone access,
// then flips DONE_TOGGLE for the return-path synchroniser.
module adbg_wb_xfer_engine
    import adbg_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADBG_ADDR_W,
    parameter int DATA_WIDTH     = ADBG_DATA_W,
    parameter int TIMEOUT_CYCLES = ADBG_TIMEOUT_DEF,
    parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                    WB_CLK,
    input  logic                    RESET,
    input  logic                    REQ_IN,
    output logic                    REQ_CLR,
    input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic                    CMD_WE,
    input  logic [DATA_WIDTH/8-1:0] CMD_SEL,
    input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic                    RSP_ERR,
    output logic                    DONE_TOGGLE,
    output logic                    BUSY,
    output logic [ADDR_WIDTH-1:0]   WB_ADR_O,
    output logic [DATA_WIDTH-1:0]   WB_DAT_O,
    input  logic [DATA_WIDTH-1:0]   WB_DAT_I,
    output logic [DATA_WIDTH/8-1:0] WB_SEL_O,
    output logic                    WB_WE_O,
    output logic                    WB_CYC_O,
    output logic                    WB_STB_O,
    input  logic                    WB_ACK_I,
    input  logic                    WB_ERR_I
);

    localparam int SW = DATA_WIDTH / 8;

    xfer_state_e           state_q, state_d;
    logic                  req_clr_q, req_clr_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  cyc_q, cyc_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  tog_q, tog_d;
    logic                  busy_q, busy_d;
    logic                  to_tc;
    logic                  bus_exit;

    adbg_wb_timeout #(
        .MAX (TIMEOUT_CYCLES),
        .W   (TO_WIDTH)
    ) u_timeout (
        .clk_i      (WB_CLK),
        .rst_i      (RESET),
        .clr_i      (state_q == S_DONE),
        .load_i     (state_q == S_CLEAR),
        .load_val_i ('0),
        .en_i       (state_q == S_BUS),
        .tc_o       (to_tc)
    );

    always_comb begin
        state_d   = state_q;
        req_clr_d = req_clr_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        rsp_err_d = rsp_err_q;
        rdata_d   = rdata_q;
        tog_d     = tog_q;
        bus_exit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (REQ_IN) begin
                    state_d   = S_CLEAR;
                    adr_d     = CMD_ADDR;
                    wdat_d    = CMD_WDATA;
                    sel_d     = CMD_SEL;
                    we_d      = CMD_WE;
                    req_clr_d = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d   = S_BUS;
                req_clr_d = 1'b0;
                cyc_d     = 1'b1;
            end
            S_BUS: begin
                // ERR takes priority over a simultaneous ACK.
                if (WB_ERR_I) begin
                    rsp_err_d = 1'b1;
                    bus_exit  = 1'b1;
                end else if (WB_ACK_I) begin
                    if (!we_q) rdata_d = WB_DAT_I;
                    rsp_err_d = 1'b0;
                    bus_exit  = 1'b1;
                end else if (to_tc) begin
                    rsp_err_d = 1'b1;
                    bus_exit  = 1'b1;
                end
                if (bus_exit) begin
                    cyc_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tog_d   = ~tog_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge WB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            req_clr_q <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            rdata_q   <= '0;
            tog_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_clr_q <= req_clr_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            rsp_err_q <= rsp_err_d;
            rdata_q   <= rdata_d;
            tog_q     <= tog_d;
            busy_q    <= busy_d;
        end
    end

    assign REQ_CLR     = req_clr_q;
    assign RSP_RDATA   = rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign DONE_TOGGLE = tog_q;
    assign BUSY        = busy_q;
    assign WB_ADR_O    = adr_q;
    assign WB_DAT_O    = wdat_q;
    assign WB_SEL_O    = sel_q;
    assign WB_WE_O     = we_q;
    assign WB_CYC_O    = cyc_q;
    assign WB_STB_O    = cyc_q;

endmodule

// File: tb/tb_adbg_wb_xfer_engine.sv
// Scoreboard bench for adbg_wb_xfer_engine with a bench-side bus slave.
module tb_adbg_wb_xfer_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [AW-1:0] cadr = '0;
    logic          cwe = 1'b0;
    logic [SW-1:0] csel = '0;
    logic [DW-1:0] cwd = '0;
    logic [DW-1:0] dat_i = '0;
    logic          ack = 1'b0;
    logic          err = 1'b0;

    logic          req_clr;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          done_tog;
    logic          busy;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_stb;

    adbg_wb_xfer_engine #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .WB_CLK      (clk),
        .RESET       (rst),
        .REQ_IN      (req),
        .REQ_CLR     (req_clr),
        .CMD_ADDR    (cadr),
        .CMD_WE      (cwe),
        .CMD_SEL     (csel),
        .CMD_WDATA   (cwd),
        .RSP_RDATA   (rsp_rdata),
        .RSP_ERR     (rsp_err),
        .DONE_TOGGLE (done_tog),
        .BUSY        (busy),
        .WB_ADR_O    (wb_adr),
        .WB_DAT_O    (wb_dat_o),
        .WB_DAT_I    (dat_i),
        .WB_SEL_O    (wb_sel),
        .WB_WE_O     (wb_we),
        .WB_CYC_O    (wb_cyc),
        .WB_STB_O    (wb_stb),
        .WB_ACK_I    (ack),
        .WB_ERR_I    (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic          we;
        logic [SW-1:0] sel;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic          er;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] model_rd = '0;
    logic          exp_tog = 1'b0;
    int            tests = 0;
    int            fails = 0;
    int            toggles = 0;
    int            clr_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: response derives only from slave outcome and last read.
    function automatic void push(input logic we, input logic [AW-1:0] adr,
                                 input logic [SW-1:0] sel,
                                 input logic [DW-1:0] wd, input int kind,
                                 input logic [DW-1:0] data);
        exp_t e;
        if (kind == K_ACK && !we) model_rd = data;
        e.adr = adr;
        e.we  = we;
        e.sel = sel;
        e.wd  = wd;
        e.rd  = model_rd;
        e.er  = (kind != K_ACK);
        q.push_back(e);
        exp_tog = ~exp_tog;
    endfunction

    // Monitor: bus fields while STB, response on each done toggle.
    logic prev_tog = 1'b0;
    int   clr_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_tog = 1'b0;
            clr_run  = 0;
        end else begin
            if (wb_stb && wb_cyc) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_unexpected: STB with empty queue");
                end else begin
                    chk("wb_adr", wb_adr, q[0].adr);
                    chk("wb_we", 32'(wb_we), 32'(q[0].we));
                    chk("wb_sel", 32'(wb_sel), 32'(q[0].sel));
                    if (q[0].we) chk("wb_dat_o", wb_dat_o, q[0].wd);
                end
            end
            if (done_tog !== prev_tog) begin
                toggles++;
                prev_tog = done_tog;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: toggle with empty queue");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rd);
                    chk("rsp_err", 32'(rsp_err), 32'(e.er));
                end
            end
            if (req_clr) begin
                if (clr_run == 0) clr_pulses++;
                clr_run++;
            end else if (clr_run != 0) begin
                chk("req_clr_len", clr_run, 1);
                clr_run = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] adr,
                         input logic [SW-1:0] sel, input logic [DW-1:0] wd,
                         output bit ok);
        int n;
        @(negedge clk);
        cadr = adr;
        cwe  = we;
        csel = sel;
        cwd  = wd;
        req  = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 12) begin
            @(negedge clk);
            n++;
            if (req_clr) req = 1'b0;
            if (wb_stb) ok = 1'b1;
        end
        req = 1'b0;
        chk("stb_latency", n, 2);
    endtask

    task automatic serve(input int kind, input int waits,
                         input logic [DW-1:0] data);
        int n;
        dat_i = $urandom;
        if (kind == K_NONE) begin
            n = 0;
            while (wb_stb && n < 3 * TO) begin
                n++;
                @(negedge clk);
            end
            chk("timeout_stb_cycles", n, TO);
        end else begin
            repeat (waits) @(negedge clk);
            dat_i = data;
            ack   = (kind != K_ERR);
            err   = (kind != K_ACK);
            @(negedge clk);
            ack   = 1'b0;
            err   = 1'b0;
            dat_i = $urandom;
            chk("stb_dropped", 32'(wb_stb), 0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 0);
        chk("done_toggle", 32'(done_tog), 32'(exp_tog));
    endtask

    task automatic xfer(input logic we, input logic [AW-1:0] adr,
                        input logic [SW-1:0] sel, input logic [DW-1:0] wd,
                        input int kind, input int waits,
                        input logic [DW-1:0] data);
        bit ok;
        push(we, adr, sel, wd, kind, data);
        issue(we, adr, sel, wd, ok);
        if (ok) serve(kind, waits, data);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int tog0;
        int p0;
        repeat (3) @(negedge clk);
        chk("rst_req_clr", 32'(req_clr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cyc_stb", 32'({wb_cyc, wb_stb}), 0);
        chk("rst_done_tog", 32'(done_tog), 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", 32'(rsp_err), 0);
        rst = 1'b0;

        xfer(1'b0, 32'h0000_1000, 4'hF, 32'h0, K_ACK, 0, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h0000_2004, 4'b0011, 32'h1234_5678, K_ACK, 3,
             32'hCAFE_F00D);
        xfer(1'b0, 32'h0000_3000, 4'hF, 32'h0, K_NONE, 0, 32'h0);
        xfer(1'b0, 32'h0000_4000, 4'hF, 32'h0, K_BOTH, 1, 32'h5555_AAAA);
        xfer(1'b0, 32'h0000_5000, 4'hF, 32'h0, K_ERR, 2, 32'h7777_7777);

        // A second request held during BUS must wait for IDLE.
        tog0 = toggles;
        p0   = clr_pulses;
        push(1'b0, 32'h0000_6000, 4'hF, 32'h0, K_ACK, 32'hA5A5_0001);
        push(1'b1, 32'h0000_6004, 4'b1100, 32'h0BAD_CAFE, K_ACK, 32'h0);
        issue(1'b0, 32'h0000_6000, 4'hF, 32'h0, ok);
        cadr = 32'h0000_6004;
        cwe  = 1'b1;
        csel = 4'b1100;
        cwd  = 32'h0BAD_CAFE;
        req  = 1'b1;
        if (ok) serve(K_ACK, 4, 32'hA5A5_0001);
        chk("held_req_pulses", clr_pulses - p0, 1);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            n++;
            if (req_clr) req = 1'b0;
            if (wb_stb) ok = 1'b1;
        end
        req = 1'b0;
        chk("held_req_accepted", 32'(ok), 1);
        if (ok) serve(K_ACK, 0, 32'h0);
        wait_idle();
        chk("held_req_toggles", toggles - tog0, 2);
        chk("held_req_clr_total", clr_pulses - p0, 2);

        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = ($urandom_range(0, 9) < 6) ? K_ACK
                                              : int'($urandom_range(1, 3));
            xfer(1'($urandom), $urandom, 4'($urandom), $urandom, kind,
                 int'($urandom_range(0, 5)), $urandom);
        end
        if (!exp_tog)
            xfer(1'b0, 32'h0000_7000, 4'hF, 32'h0, K_ACK, 0, 32'h1357_9BDF);

        // Asynchronous reset in the middle of a stalled access.
        push(1'b0, 32'h0000_8000, 4'hF, 32'h0, K_NONE, 32'h0);
        issue(1'b0, 32'h0000_8000, 4'hF, 32'h0, ok);
        @(negedge clk);
        chk("pre_rst_tog", 32'(done_tog), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(wb_cyc), 0);
        chk("arst_stb", 32'(wb_stb), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_tog", 32'(done_tog), 0);
        q.delete();
        model_rd = '0;
        exp_tog  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 32'h0000_9000, 4'hF, 32'h0, K_ACK, 1, 32'h2468_ACE0);
        xfer(1'b1, 32'h0000_9004, 4'h1, 32'h0000_00FF, K_ACK, 0, 32'h0);

        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d left, need 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adbg_wb_xfer_engine.md
Name: adbg_wb_xfer_engine

Overview:
WishBone-clock-domain transaction engine for the OR1K debug bridge. It consumes the request strobe produced by the toggle synchroniser (JTAG→WB crossing) and clears that synchroniser's held flag. It then runs a single WishBone master access using the quasi-static command fields held by the JTAG side. On completion it flips a done toggle that the return-path synchroniser carries back to the TCK domain.

Parameters:
ADDR_WIDTH, 32, WishBone address width
DATA_WIDTH, 32, WishBone data width
TIMEOUT_CYCLES, 255, max cycles waiting for ACK/ERR before abort; must be ≥1
TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
WB_CLK  input  1  WishBone clock; sole clock of block
RESET  input  1  asynchronous, active-high reset
REQ_IN  input  1  request strobe from toggle synchroniser output
REQ_CLR  output  1  clear for the synchroniser's set/reset flop
CMD_ADDR  input  ADDR_WIDTH  access address; stable while request pending
CMD_WE  input  1  1=write, 0=read
CMD_SEL  input  DATA_WIDTH/8  byte selects
CMD_WDATA  input  DATA_WIDTH  write data
RSP_RDATA  output  DATA_WIDTH  captured read data
RSP_ERR  output  1  1 = last access ended with ERR_I or timeout
DONE_TOGGLE  output  1  inverts once per completed access (source for return synchroniser)
BUSY  output  1  engine not IDLE
WB_ADR_O  output  ADDR_WIDTH  bus address
WB_DAT_O  output  DATA_WIDTH  bus write data
WB_DAT_I  input  DATA_WIDTH  bus read data
WB_SEL_O  output  DATA_WIDTH/8  bus byte selects
WB_WE_O  output  1  bus write enable
WB_CYC_O  output  1  bus cycle
WB_STB_O  output  1  bus strobe
WB_ACK_I  input  1  bus acknowledge
WB_ERR_I  input  1  bus error

Behaviour:
- Reset values, applied asynchronously: all outputs 0; FSM=IDLE; timeout counter 0; DONE_TOGGLE 0.
- All outputs are registered.
- FSM states: IDLE, CLEAR, BUS, DONE.
- IDLE: if REQ_IN=1, go to CLEAR. Same edge captures CMD_* into WB_ADR_O/WB_DAT_O/WB_SEL_O/WB_WE_O and sets REQ_CLR=1.
- CLEAR: lasts exactly 1 cycle, with REQ_CLR=1 during it, which clears the synchroniser flag. REQ_IN is ignored here and in BUS/DONE. Go to BUS and set WB_CYC_O=WB_STB_O=1; REQ_CLR returns to 0 at that edge.
- BUS: the timeout counter increments each cycle.
  - ACK_I=1: latch WB_DAT_I into RSP_RDATA (reads only; writes leave RSP_RDATA unchanged); RSP_ERR=0.
  - ERR_I=1: RSP_ERR=1; RSP_RDATA unchanged.
  - ACK_I and ERR_I together: ERR wins.
  - Counter reaches TIMEOUT_CYCLES with no ACK/ERR: RSP_ERR=1.
  - Any of these three exits: CYC/STB drop at that edge; go to DONE.
- DONE: invert DONE_TOGGLE; clear counter; go to IDLE. DONE lasts 1 cycle. RSP_* are stable from entry to DONE until the next completion.
- Latency, request accepted → first STB: 2 edges (IDLE→CLEAR→BUS). ACK with zero wait states → DONE_TOGGLE flips 2 edges after the ACK sample edge.
- A request arriving while BUSY is not lost: the synchroniser flag holds it, because REQ_CLR pulses only in CLEAR. It is accepted on return to IDLE. The JTAG side must not issue one before DONE returns; no queueing beyond that single flag.
- Reset mid-BUS: CYC/STB drop immediately (async). DONE_TOGGLE returns to 0 without a flip; the TCK side resynchronises via its own reset.
- BUSY=1 in CLEAR, BUS, DONE.

Decomposition:
- Shared package adbg_wb_pkg holds:
  - FSM state enum (IDLE, CLEAR, BUS, DONE), 2-bit encoding
  - default widths
  - default timeout constant
- Sub-module adbg_wb_timeout: loadable up-counter with clear, enable and terminal-count output.
- The engine instantiates no synchroniser; the toggle synchroniser is instantiated alongside it at top level.

Test Plan:
1. REQ_IN 1-cycle pulse; CMD_WE=0, ADDR=0x0000_1000; ACK_I with 0 wait, DAT_I=0xDEADBEEF → REQ_CLR high exactly 1 cycle; STB 2 edges after accept; RSP_RDATA=0xDEADBEEF, RSP_ERR=0; DONE_TOGGLE 0→1.
2. Write: WE=1, SEL=4'b0011, WDATA=0x12345678, ACK after 3 waits → WB_DAT_O/SEL_O match during STB; RSP_RDATA unchanged; DONE_TOGGLE flips back to 0.
3. No ACK, TIMEOUT_CYCLES=8 → STB high 8 cycles then drops; RSP_ERR=1; DONE_TOGGLE flips once.
4. ACK_I and ERR_I asserted on the same cycle → RSP_ERR=1, RSP_RDATA unchanged.
5. Second REQ_IN held high during BUS → no action until IDLE; then accepted with a fresh REQ_CLR pulse; exactly two toggles total.
6. RESET asserted mid-BUS, asynchronous to clock edge → CYC/STB/BUSY/DONE_TOGGLE go 0 immediately, before the next WB_CLK edge; after release, the next REQ_IN is accepted normally.
